// File: rtl/intc_pkg.sv
// Shared definitions for the intc interrupt controller: register offsets,
// FSM state encoding, CLAIM layout and small priority helpers.
package intc_pkg;

    localparam logic [2:0] INTC_REG_ENABLE     = 3'd0;
    localparam logic [2:0] INTC_REG_PENDING    = 3'd1;
    localparam logic [2:0] INTC_REG_MODE       = 3'd2;
    localparam logic [2:0] INTC_REG_IN_SERVICE = 3'd3;
    localparam logic [2:0] INTC_REG_CLAIM      = 3'd4;
    localparam logic [2:0] INTC_REG_SWI        = 3'd5;

    localparam int INTC_CLAIM_VALID_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } intc_state_e;

    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intc_if.sv
// Data-memory style slave bus used to reach the intc register file.
interface intc_if;
    logic        cs;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (output cs, rd, addr, write_data, input read_data);
    modport slave  (input cs, rd, addr, write_data, output read_data);
endinterface

// File: rtl/intc_sync_edge.sv
// Per-source two-flop synchroniser with a trailing flop for rising-edge detection.
module intc_sync_edge (
    input  logic clk,
    input  logic clr_n,
    input  logic src,
    output logic level,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // synchroniser chain plus one delayed copy of the synchronised level
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= src;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign level = sync2_r;
    assign rise  = sync2_r & ~prev_r;

endmodule

// File: rtl/intc.sv
// Programmable interrupt controller presenting one prioritised request to CP0.
// Optional nested servicing is enabled by defining INTC_NEST_EN.
module intc
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [NUM_SRC-1:0] irq_src,
    intc_if.slave              bus,
    output logic [7:0]         hardware_interrupt,
    input  logic               ack,
    input  logic               eret,
    output logic               irq_active
);

    localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);

    logic [7:0]  level_s;
    logic [7:0]  rise_s;
    logic [7:0]  enable_r;
    logic [7:0]  mode_r;
    logic [7:0]  pending_r;
    logic [7:0]  isr_r;
    logic [7:0]  hw_int_r;
    logic        irq_active_r;
    intc_state_e state_r;
    intc_state_e state_nxt_s;
    logic [7:0]  enable_nxt_s;
    logic [7:0]  mode_nxt_s;
    logic [7:0]  pending_nxt_s;
    logic [7:0]  isr_nxt_s;
    logic [7:0]  hw_int_nxt_s;
    logic [7:0]  wdata_s;
    logic [7:0]  w1c_s;
    logic [7:0]  swi_s;
    logic [7:0]  ack_bits_s;
    logic [7:0]  eret_bits_s;
    logic [7:0]  nest_gate_s;
    logic [7:0]  cand_s;
    logic        wr_s;
    logic        ack_ok_s;
    logic        eret_ok_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    for (genvar gi = 0; gi < 8; gi++) begin : g_src
        if (gi < NUM_SRC) begin : g_used
            intc_sync_edge u_sync (
                .clk   (clk),
                .clr_n (clr_n),
                .src   (irq_src[gi]),
                .level (level_s[gi]),
                .rise  (rise_s[gi])
            );
        end else begin : g_unused
            assign level_s[gi] = 1'b0;
            assign rise_s[gi]  = 1'b0;
        end
    end

    assign wr_s     = bus.cs & ~bus.rd;
    assign wdata_s  = bus.write_data[7:0] & SRC_MASK;
    assign unused_s = ^{bus.addr[7:3], bus.write_data[31:8]};

    // register writes, pending update and in-service bookkeeping
    always_comb begin
        enable_nxt_s = enable_r;
        mode_nxt_s   = mode_r;
        w1c_s        = 8'd0;
        swi_s        = 8'd0;
        if (wr_s) begin
            case (bus.addr[2:0])
                INTC_REG_ENABLE:  enable_nxt_s = wdata_s;
                INTC_REG_PENDING: w1c_s        = wdata_s;
                INTC_REG_MODE:    mode_nxt_s   = wdata_s;
                INTC_REG_SWI:     swi_s        = wdata_s;
                default:          swi_s        = 8'd0;
            endcase
        end else begin
            swi_s = 8'd0;
        end
        ack_ok_s    = ack & (state_r == ST_REQ) & (hw_int_r != 8'd0);
        eret_ok_s   = eret & (isr_r != 8'd0);
        ack_bits_s  = ack_ok_s ? hw_int_r : 8'd0;
        eret_bits_s = eret_ok_s ? lowest_onehot(isr_r) : 8'd0;
        // a fresh source edge outranks a W1C or an ack clear on the same bit
        pending_nxt_s = ((mode_r & ((pending_r & ~w1c_s & ~ack_bits_s) | rise_s))
                         | (~mode_r & level_s) | swi_s) & SRC_MASK;
        isr_nxt_s     = (isr_r | ack_bits_s) & ~eret_bits_s;
    end

    // candidate set, restricted while a handler is in service
    always_comb begin
        nest_gate_s = 8'hFF;
        if (isr_r == 8'd0) begin
            nest_gate_s = 8'hFF;
        end else begin
`ifdef INTC_NEST_EN
            nest_gate_s = lowest_onehot(isr_r) - 8'd1;
`else
            nest_gate_s = 8'h00;
`endif
        end
        cand_s = pending_r & enable_r & ~isr_r & nest_gate_s;
    end

    // request FSM: next state and next one-hot request
    always_comb begin
        state_nxt_s  = state_r;
        hw_int_nxt_s = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (cand_s != 8'd0) begin
                    state_nxt_s  = ST_REQ;
                    hw_int_nxt_s = lowest_onehot(cand_s);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_ok_s) begin
                    state_nxt_s = ST_SVC;
                end else if (eret_ok_s) begin
                    state_nxt_s = (isr_nxt_s != 8'd0) ? ST_SVC : ST_IDLE;
                end else if (cand_s != 8'd0) begin
                    state_nxt_s  = ST_REQ;
                    hw_int_nxt_s = lowest_onehot(cand_s);
                end else begin
                    state_nxt_s = (isr_r != 8'd0) ? ST_SVC : ST_IDLE;
                end
            end
            ST_SVC: begin
                if (eret_ok_s) begin
                    state_nxt_s = (isr_nxt_s != 8'd0) ? ST_SVC : ST_IDLE;
                end else if (cand_s != 8'd0) begin
                    state_nxt_s  = ST_REQ;
                    hw_int_nxt_s = lowest_onehot(cand_s);
                end else begin
                    state_nxt_s = ST_SVC;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // all controller state, cleared immediately by clr_n
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            enable_r     <= 8'd0;
            mode_r       <= 8'd0;
            pending_r    <= 8'd0;
            isr_r        <= 8'd0;
            hw_int_r     <= 8'd0;
            irq_active_r <= 1'b0;
            state_r      <= ST_IDLE;
        end else begin
            enable_r     <= enable_nxt_s;
            mode_r       <= mode_nxt_s;
            pending_r    <= pending_nxt_s;
            isr_r        <= isr_nxt_s;
            hw_int_r     <= hw_int_nxt_s;
            irq_active_r <= (isr_nxt_s != 8'd0);
            state_r      <= state_nxt_s;
        end
    end

    // zero-latency read mux, like data RAM
    always_comb begin
        rdata_s = 32'd0;
        if (bus.cs & bus.rd) begin
            case (bus.addr[2:0])
                INTC_REG_ENABLE:     rdata_s = {24'd0, enable_r};
                INTC_REG_PENDING:    rdata_s = {24'd0, pending_r};
                INTC_REG_MODE:       rdata_s = {24'd0, mode_r};
                INTC_REG_IN_SERVICE: rdata_s = {24'd0, isr_r};
                INTC_REG_CLAIM: begin
                    rdata_s[INTC_CLAIM_VALID_BIT] = (isr_r != 8'd0);
                    rdata_s[2:0]                  = lowest_index(isr_r);
                end
                default:             rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.read_data       = rdata_s;
    assign hardware_interrupt  = hw_int_r;
    assign irq_active          = irq_active_r;

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_intc;

    localparam logic [2:0] A_EN    = 3'd0;
    localparam logic [2:0] A_PEND  = 3'd1;
    localparam logic [2:0] A_MODE  = 3'd2;
    localparam logic [2:0] A_ISR   = 3'd3;
    localparam logic [2:0] A_CLAIM = 3'd4;
    localparam logic [2:0] A_SWI   = 3'd5;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] irq_src;
    logic [7:0] hardware_interrupt;
    logic       ack;
    logic       eret;
    logic       irq_active;

    intc_if bus ();

    intc #(.NUM_SRC(8)) dut (
        .clk                (clk),
        .clr_n              (clr_n),
        .irq_src            (irq_src),
        .bus                (bus),
        .hardware_interrupt (hardware_interrupt),
        .ack                (ack),
        .eret               (eret),
        .irq_active         (irq_active)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_en, m_pend, m_mode, m_isr, m_hw;
    logic       m_act;
    logic [7:0] hist [3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 8'd0; m_pend = 8'd0; m_mode = 8'd0; m_isr = 8'd0; m_hw = 8'd0; m_act = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 8'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            3'd0: v = {24'd0, m_en};
            3'd1: v = {24'd0, m_pend};
            3'd2: v = {24'd0, m_mode};
            3'd3: v = {24'd0, m_isr};
            3'd4: begin
                for (int i = 7; i >= 0; i--) if (m_isr[i]) v = 32'h8000_0000 + 32'(i);
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // One rising edge of the behavioural model, using the inputs present at the edge.
    task automatic model_edge();
        logic [7:0] lvl, rise, w1c, swi, isr_n, pend_n, hw_n;
        logic       ack_ok, eret_ok, wr;
        int         low, win;
        if (!clr_n) begin
            model_reset();
            return;
        end
        lvl  = hist[1];
        rise = hist[1] & ~hist[2];
        wr   = bus.cs && !bus.rd;
        w1c  = (wr && bus.addr[2:0] == 3'd1) ? bus.write_data[7:0] : 8'd0;
        swi  = (wr && bus.addr[2:0] == 3'd5) ? bus.write_data[7:0] : 8'd0;
        ack_ok  = ack && (m_hw != 8'd0);
        eret_ok = eret && (m_isr != 8'd0);
        low = 8;
        for (int i = 7; i >= 0; i--) if (m_isr[i]) low = i;
        win = -1;
        for (int i = 0; i < 8; i++) begin
            if (win < 0 && m_pend[i] && m_en[i] && !m_isr[i]) begin
`ifdef INTC_NEST_EN
                if (i < low) win = i;
`else
                if (low == 8) win = i;
`endif
            end
        end
        hw_n = 8'd0;
        if (!ack_ok && !eret_ok && win >= 0) hw_n[win] = 1'b1;
        isr_n = m_isr;
        if (ack_ok) isr_n = isr_n | m_hw;
        if (eret_ok) isr_n[low] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i])
                pend_n[i] = (m_pend[i] && !w1c[i] && !(ack_ok && m_hw[i])) || rise[i] || swi[i];
            else
                pend_n[i] = lvl[i] || swi[i];
        end
        if (wr && bus.addr[2:0] == 3'd0) m_en = bus.write_data[7:0];
        if (wr && bus.addr[2:0] == 3'd2) m_mode = bus.write_data[7:0];
        m_pend = pend_n;
        m_isr  = isr_n;
        m_hw   = hw_n;
        m_act  = (isr_n != 8'd0);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = irq_src;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("hw_int", {24'd0, hardware_interrupt}, {24'd0, m_hw});
        check_val("irq_active", {31'd0, irq_active}, {31'd0, m_act});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.rd = 1'b0; bus.addr = {5'd0, a}; bus.write_data = {24'd0, d};
        step();
        bus.cs = 1'b0; bus.rd = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = {5'($urandom), a};
        #1;
        check_val(tag, bus.read_data, exp);
        bus.cs = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic fire(input logic [7:0] m);
        irq_src = irq_src | m; step(); irq_src = irq_src & ~m;
    endtask

    initial begin
        clr_n = 1'b0; irq_src = 8'd0; ack = 1'b0; eret = 1'b0;
        bus.cs = 1'b0; bus.rd = 1'b1; bus.addr = 8'd0; bus.write_data = 32'd0;
        model_reset();
        steps(2);
        clr_n = 1'b1;
        for (int a = 0; a < 8; a++) rd_chk("reset_read", 3'(a), 32'd0);
        check_val("reset_hw", {24'd0, hardware_interrupt}, 32'd0);
        step();

        // single edge-triggered source
        wr(A_EN, 8'h05);
        wr(A_MODE, 8'h05);
        fire(8'h04);
        steps(2);
        rd_chk("pend_set", A_PEND, 32'h04);
        step();
        check_val("req_src2", {24'd0, hardware_interrupt}, 32'h04);
        pulse_ack();
        check_val("ack_drop", {24'd0, hardware_interrupt}, 32'h00);
        check_val("ack_active", {31'd0, irq_active}, 32'd1);
        rd_chk("isr_after_ack", A_ISR, 32'h04);
        rd_chk("pend_after_ack", A_PEND, 32'h00);
        rd_chk("claim", A_CLAIM, 32'h8000_0002);
        pulse_eret();
        rd_chk("isr_after_eret", A_ISR, 32'h00);
        check_val("eret_inactive", {31'd0, irq_active}, 32'd0);
        step();

        // two sources in the same cycle: lowest index first
        fire(8'h05);
        steps(3);
        check_val("prio_first", {24'd0, hardware_interrupt}, 32'h01);
        pulse_ack();
        pulse_eret();
        step();
        check_val("prio_second", {24'd0, hardware_interrupt}, 32'h04);
        pulse_ack();
        pulse_eret();
        step();

        // level source held through eret re-requests
        wr(A_EN, 8'h0D);
        irq_src[3] = 1'b1;
        steps(4);
        check_val("level_req", {24'd0, hardware_interrupt}, 32'h08);
        pulse_ack();
        rd_chk("level_isr", A_ISR, 32'h08);
        pulse_eret();
        step();
        check_val("level_rereq", {24'd0, hardware_interrupt}, 32'h08);
        irq_src[3] = 1'b0;
        steps(4);
        check_val("level_drop", {24'd0, hardware_interrupt}, 32'h00);
        rd_chk("level_pend_low", A_PEND, 32'h00);

        // software set and write-1-to-clear
        wr(A_EN, 8'h05);
        wr(A_MODE, 8'h0D);
        wr(A_SWI, 8'h08);
        rd_chk("swi_set", A_PEND, 32'h08);
        wr(A_PEND, 8'h08);
        rd_chk("w1c_clear", A_PEND, 32'h00);

        // lower-index source firing while another is in service
        wr(A_EN, 8'h12);
        wr(A_MODE, 8'h12);
        fire(8'h10);
        steps(3);
        check_val("svc4_req", {24'd0, hardware_interrupt}, 32'h10);
        pulse_ack();
        rd_chk("svc4_isr", A_ISR, 32'h10);
        fire(8'h02);
        steps(3);
`ifdef INTC_NEST_EN
        check_val("nest_req", {24'd0, hardware_interrupt}, 32'h02);
        pulse_ack();
        rd_chk("nest_isr", A_ISR, 32'h12);
        pulse_eret();
        rd_chk("nest_eret", A_ISR, 32'h10);
        pulse_eret();
`else
        check_val("no_nest_req", {24'd0, hardware_interrupt}, 32'h00);
        steps(2);
        check_val("no_nest_hold", {24'd0, hardware_interrupt}, 32'h00);
        pulse_eret();
        step();
        check_val("after_eret_req", {24'd0, hardware_interrupt}, 32'h02);
        pulse_ack();
        pulse_eret();
`endif
        step();

        // asynchronous reset while in service with pending bits set
        wr(A_EN, 8'h01);
        wr(A_MODE, 8'h0F);
        wr(A_SWI, 8'h0F);
        step();
        check_val("pre_rst_req", {24'd0, hardware_interrupt}, 32'h01);
        pulse_ack();
        wr(A_SWI, 8'h0F);
        rd_chk("pre_rst_pend", A_PEND, 32'h0F);
        rd_chk("pre_rst_isr", A_ISR, 32'h01);
        clr_n = 1'b0;
        #1;
        check_val("rst_hw_now", {24'd0, hardware_interrupt}, 32'd0);
        check_val("rst_act_now", {31'd0, irq_active}, 32'd0);
        for (int a = 0; a < 8; a++) rd_chk("rst_read_now", 3'(a), 32'd0);
        model_reset();
        step();
        clr_n = 1'b1;
        steps(4);
        check_val("post_rst_quiet", {24'd0, hardware_interrupt}, 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] a;
            a = 3'($urandom_range(0, 7));
            rd_chk("rand_read", a, model_read(a));
            if ($urandom_range(0, 9) == 0) irq_src = irq_src ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 99) < 20) begin
                bus.cs = 1'b1; bus.rd = 1'b0;
                bus.addr = 8'($urandom_range(0, 255));
                bus.write_data = $urandom;
            end
            ack  = ($urandom_range(0, 3) == 0);
            eret = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                clr_n = 1'b0;
                #1;
                check_val("rand_rst_hw", {24'd0, hardware_interrupt}, 32'd0);
                check_val("rand_rst_act", {31'd0, irq_active}, 32'd0);
                model_reset();
            end
            step();
            clr_n = 1'b1; bus.cs = 1'b0; bus.rd = 1'b1; ack = 1'b0; eret = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/intc.md
# intc

Programmable interrupt controller that drives the CPU's `hardware_interrupt[7:0]` input to coprocessor 0 and tracks acknowledge and `eret` from it. It sits on the data-memory bus as a memory-mapped slave with the same `cs`/`rd`/`addr`/`write_data`/`read_data` signalling as data RAM. It synchronises up to eight external sources, latches them as edge- or level-triggered pending bits, masks them, and presents one prioritised request at a time.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..8; unused `hardware_interrupt` bits are tied 0.
- `clk`  in  1: system clock, all state on rising edge.
- `clr_n`  in  1: asynchronous, active-low reset.
- `irq_src`  in  NUM_SRC: raw source lines, asynchronous to `clk`.
- `cs`  in  1: slave select from the data bus.
- `rd`  in  1: 1 = read, 0 = write (when `cs`=1).
- `addr`  in  8: word address; only `addr[2:0]` is decoded.
- `write_data`  in  32: write data.
- `read_data`  out  32: read data; combinational, valid when `cs & rd`, otherwise 0.
- `hardware_interrupt`  out  8: registered one-hot request to CP0.
- `ack`  in  1: one-cycle pulse; CP0 has taken the presented request.
- `eret`  in  1: one-cycle pulse; the handler has returned.
- `irq_active`  out  1: registered; 1 while any IN_SERVICE bit is set.

## Operation
- Register map (`addr[2:0]`):
  - 0 ENABLE: read/write mask.
  - 1 PENDING: read; write-1-to-clear.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 IN_SERVICE: read-only.
  - 4 CLAIM: read-only; bit31 = valid, `[2:0]` = lowest set IN_SERVICE index.
  - 5 SWI: write-1-to-set PENDING.
  - 6–7: read 0, writes ignored.
- Bits at and above NUM_SRC read 0 and ignore writes.
- Writes take effect on the rising edge with `cs & !rd`.
- Each source passes a 2-flop synchroniser. Edge mode sets PENDING on a synchronised 0→1 transition. Level mode sets PENDING to the synchronised level every cycle; W1C has no lasting effect while the line is high.
- Priority: lowest index wins. Candidate set = PENDING & ENABLE & ~IN_SERVICE, further gated by nesting rules (see Configuration).
- States:
  - IDLE: no request.
  - REQ: `hardware_interrupt` = one-hot of the winner.
  - SVC: IN_SERVICE non-empty, no request.
  - Transitions: IDLE→REQ when the candidate set is non-empty. REQ→SVC on `ack`. SVC→IDLE on `eret` when IN_SERVICE becomes empty.
- `ack` sets IN_SERVICE at the presented index. In edge mode it also clears that PENDING bit on the same edge.
- `eret` clears the lowest-index IN_SERVICE bit.
- Boundary rules:
  - `ack` while `hardware_interrupt`=0 is ignored.
  - `eret` with IN_SERVICE=0 is ignored.
  - Source edge and W1C on the same bit in the same cycle: set wins.
  - Source edge and `ack` on the same bit in the same cycle: set wins, so the bit re-pends.
  - Clearing ENABLE or PENDING while in REQ drops `hardware_interrupt` on the next edge, with no state corruption.
  - Level source still high at `eret`: re-requests.
  - `clr_n` low at any time: all registers, synchroniser flops and outputs go to 0 immediately, whatever state the FSM is in.

## Timing
- Reset values: ENABLE=0, PENDING=0, MODE=0, IN_SERVICE=0, `hardware_interrupt`=0, `irq_active`=0, state IDLE.
- Request latency: `irq_src` rises before edge E0 → PENDING set at E2 → `hardware_interrupt` valid after E3.
- From register-driven change to `hardware_interrupt`: 1 edge. This covers SWI, ENABLE and PENDING writes.
- `ack` at edge E → `hardware_interrupt`=0 and `irq_active`=1 after E.
- `eret` at edge E → next request can appear after E+1.
- Read path has zero latency, same as data RAM.

## Configuration
- `INTC_NEST_EN` defined:
  - A candidate may request while in SVC if its index is lower than the lowest set IN_SERVICE index.
  - `ack` then adds a bit, so nesting depth is up to NUM_SRC.
- `INTC_NEST_EN` not defined:
  - No request is asserted while IN_SERVICE is non-empty.
  - IN_SERVICE has at most one bit set.

## Structure
- The shared defines header holds:
  - register offsets `INTC_REG_*`
  - the FSM state encoding
  - the CLAIM valid bit position
- The sub-module `intc_sync_edge` is natural: a per-source 2-flop synchroniser plus edge detector, instantiated NUM_SRC times.
- Priority encoding and the register file stay in `intc`.

## Test plan
- After reset, read all offsets → all 0, `hardware_interrupt`=0.
- ENABLE=0x05, MODE=0x05, pulse `irq_src[2]`:
  - `hardware_interrupt`=0x04 four edges later.
  - `ack` → output 0, IN_SERVICE=0x04, PENDING=0.
  - CLAIM=0x80000002.
  - `eret` → IN_SERVICE=0.
- Sources 0 and 2 pending in the same cycle, both enabled → 0x01 first. After `ack`+`eret`, 0x04.
- Level source 3 (MODE bit 3 = 0) held high through `eret` → re-requests 0x08.
- Software W1C of PENDING with source 3 low → PENDING clears.
- With `INTC_NEST_EN`:
  - In service on 4, source 1 fires → 0x02 is requested.
  - `ack` → IN_SERVICE=0x12.
  - First `eret` → 0x10.
- Without `INTC_NEST_EN`, the same stimulus gives no request until `eret`.
- Pull `clr_n` low while in SVC with PENDING=0x0F → all outputs and registers 0 immediately. After release, no spurious request.
